core_mem_arbiter: RTL and testbench
===================================

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the address bus width.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of busy cycles awaiting mem_ack (range 1-255).
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 if_addr  in  ADDR_WIDTH  instruction-fetch address from core.
REQ-007 if_req  in  1  fetch request, held until if_ack.
REQ-008 if_rdata  out  DATA_WIDTH  fetch read data, valid when if_ack=1.
REQ-009 if_ack  out  1  one-cycle fetch completion pulse.
REQ-010 dm_addr / dm_wdata  in  ADDR_WIDTH / DATA_WIDTH  data-memory address and write data.
REQ-011 dm_req / dm_we  in  1 / 1  data request (held until dm_ack) and write enable.
REQ-012 dm_rdata  out  DATA_WIDTH  data read result, valid when dm_ack=1.
REQ-013 dm_ack  out  1  one-cycle data completion pulse.
REQ-014 mem_addr / mem_wdata / mem_we / mem_req  out  ADDR_WIDTH / DATA_WIDTH / 1 / 1  shared memory port.
REQ-015 mem_rdata / mem_ack  in  DATA_WIDTH / 1  memory read data and completion.
REQ-016 owner  out  2  current state: 0=IDLE, 1=IF_BUSY, 2=DM_BUSY.
REQ-017 timeout_err  out  1  sticky flag, set by any timeout.

Function
REQ-018 The FSM SHALL have the states IDLE, IF_BUSY and DM_BUSY; all outputs SHALL be registered.
REQ-019 In IDLE, a requester is eligible when its req=1 and its ack is not high in the same cycle.
REQ-020 In IDLE with one eligible requester, it SHALL be granted at the next edge.
REQ-021 In IDLE with both requesters eligible, grant SHALL go to the one not granted last; last_grant SHALL reset to DM, so IF wins the first tie.
REQ-022 On grant, mem_addr, mem_wdata and mem_we SHALL be captured from the winner (mem_we=0 and mem_wdata=0 for IF), mem_req SHALL rise, and last_grant SHALL update.
REQ-023 Captured values and mem_req SHALL hold stable while busy, regardless of requester inputs.
REQ-024 Latency: req first sampled in IDLE at edge N -> mem_req=1 after edge N.
REQ-025 Completion: mem_ack=1 sampled at edge M while busy -> after M: mem_req=0; the owner's rdata=mem_rdata and ack=1 for exactly one cycle; state IDLE.
REQ-026 The earliest next mem_req SHALL follow edge M+1, giving a one-cycle turnaround.
REQ-027 A requester deasserting req mid-transaction SHALL NOT abort the transaction; the ack still pulses.
REQ-028 mem_ack while IDLE SHALL be ignored.
REQ-029 A busy counter SHALL clear on grant and increment each busy cycle without mem_ack.
REQ-030 When the busy counter reaches TIMEOUT, the transaction SHALL abort: mem_req=0, the owner's ack pulses with rdata=0xDEADBEEF (truncated or zero-extended to DATA_WIDTH), timeout_err=1, state IDLE.
REQ-031 mem_ack in the same cycle as timeout expiry SHALL take precedence, giving a normal completion with no error.
REQ-032 if_rdata and dm_rdata SHALL hold their last value between acks.

Reset
REQ-033 rst=1 SHALL force, at the next edge, state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, owner=0, timeout_err=0, busy counter=0, last_grant=DM.
REQ-034 rst asserted mid-transaction SHALL drop mem_req the next cycle without generating an ack; a later mem_ack SHALL be ignored.

Verification
REQ-035 if_req=1, if_addr=0x100; mem_ack after 3 cycles with mem_rdata=0x12345678 -> mem_addr=0x100, mem_we=0; if_ack pulses once with if_rdata=0x12345678; dm_ack stays 0.
REQ-036 if_req and dm_req rise together, held continuously; mem_ack 1-cycle latency -> grant order IF, DM, IF, DM; one IDLE cycle between transactions.
REQ-037 dm_req=1, dm_we=1, dm_addr=0x200, dm_wdata=0xCAFEF00D; change dm_addr to 0x300 while busy -> mem_addr stays 0x200, mem_we=1; dm_ack pulses once after mem_ack.
REQ-038 TIMEOUT=4, dm_req=1, mem_ack never asserted -> mem_req drops after 4 busy cycles; dm_ack=1 with dm_rdata=0xDEADBEEF; timeout_err=1 and stays 1 until rst.
REQ-039 rst pulsed while IF_BUSY, then mem_ack=1 -> no if_ack; all outputs at reset values; the first post-reset tie grants IF.
REQ-040 mem_ack=1 on the exact cycle the busy counter reaches TIMEOUT -> normal ack with mem_rdata; timeout_err stays 0.

Source files
------------

// File: rtl/core_mem_arbiter_if.sv
// rtl/core_mem_arbiter_if.sv - shared memory port bundle between the arbiter and memory
interface core_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic                  mem_req;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_req,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_req,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - two-requester (fetch/data) arbiter onto one memory port with timeout
module core_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_req,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ack,
    core_mem_arbiter_if.master    mem,
    output logic [1:0]            owner,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    // Counter value at which one more ack-less busy cycle means expiry.
    localparam logic [7:0]            TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] ABORT_DATA   = DATA_WIDTH'(32'hDEADBEEF);
    localparam logic                  GRANT_IF     = 1'b0;
    localparam logic                  GRANT_DM     = 1'b1;

    state_t                state_q, state_d;
    logic [7:0]            busy_cnt_q, busy_cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_req_q, mem_req_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  if_ack_q, if_ack_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  dm_ack_q, dm_ack_d;
    logic                  err_q, err_d;

    logic                  if_elig;
    logic                  dm_elig;
    logic                  grant_dm;
    logic                  finish;
    logic [DATA_WIDTH-1:0] rsp_data;

    // Next-state and next-output decision: arbitration in IDLE, completion/timeout while busy.
    always_comb begin
        state_d      = state_q;
        busy_cnt_d   = busy_cnt_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;
        mem_req_d    = mem_req_q;
        if_rdata_d   = if_rdata_q;
        if_ack_d     = 1'b0;
        dm_rdata_d   = dm_rdata_q;
        dm_ack_d     = 1'b0;
        err_d        = err_q;
        // A requester still seeing its ack this cycle is finishing, not asking again.
        if_elig      = if_req & ~if_ack_q;
        dm_elig      = dm_req & ~dm_ack_q;
        grant_dm     = 1'b0;
        finish       = 1'b0;
        rsp_data     = ABORT_DATA;

        case (state_q)
            IDLE: begin
                grant_dm = dm_elig & (~if_elig | (last_grant_q == GRANT_IF));
                if (if_elig | dm_elig) begin
                    mem_req_d  = 1'b1;
                    busy_cnt_d = 8'd0;
                    if (grant_dm) begin
                        state_d      = DM_BUSY;
                        last_grant_d = GRANT_DM;
                        mem_addr_d   = dm_addr;
                        mem_wdata_d  = dm_wdata;
                        mem_we_d     = dm_we;
                    end else begin
                        state_d      = IF_BUSY;
                        last_grant_d = GRANT_IF;
                        mem_addr_d   = if_addr;
                        mem_wdata_d  = '0;
                        mem_we_d     = 1'b0;
                    end
                end
            end
            IF_BUSY, DM_BUSY: begin
                // A real ack beats a coincident expiry.
                finish = mem.mem_ack | (busy_cnt_q == TIMEOUT_LAST);
                if (finish) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (mem.mem_ack) begin
                        rsp_data = mem.mem_rdata;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (state_q == IF_BUSY) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = rsp_data;
                    end else begin
                        dm_ack_d   = 1'b1;
                        dm_rdata_d = rsp_data;
                    end
                end else begin
                    busy_cnt_d = busy_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and all outputs registered; reset drops any in-flight transaction silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_cnt_q   <= 8'd0;
            last_grant_q <= GRANT_DM;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_req_q    <= 1'b0;
            if_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            dm_rdata_q   <= '0;
            dm_ack_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_cnt_q   <= busy_cnt_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_req_q    <= mem_req_d;
            if_rdata_q   <= if_rdata_d;
            if_ack_q     <= if_ack_d;
            dm_rdata_q   <= dm_rdata_d;
            dm_ack_q     <= dm_ack_d;
            err_q        <= err_d;
        end
    end

    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_req   = mem_req_q;
    assign if_rdata      = if_rdata_q;
    assign if_ack        = if_ack_q;
    assign dm_rdata      = dm_rdata_q;
    assign dm_ack        = dm_ack_q;
    assign owner         = state_q;
    assign timeout_err   = err_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - bench for core_mem_arbiter: directed cases plus random traffic vs model
module tb_core_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] if_addr = '0;
    logic          if_req = 1'b0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic [1:0]    owner;
    logic          timeout_err;
    logic [DW-1:0] mem_rdata_drv = '0;
    logic          mem_ack_drv = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_req;

    core_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_bus ();

    assign mem_bus.mem_rdata = mem_rdata_drv;
    assign mem_bus.mem_ack   = mem_ack_drv;
    assign mem_addr          = mem_bus.mem_addr;
    assign mem_wdata         = mem_bus.mem_wdata;
    assign mem_we            = mem_bus.mem_we;
    assign mem_req           = mem_bus.mem_req;

    core_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_addr     (if_addr),
        .if_req      (if_req),
        .if_rdata    (if_rdata),
        .if_ack      (if_ack),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_rdata    (dm_rdata),
        .dm_ack      (dm_ack),
        .mem         (mem_bus.master),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level reference: at most one outstanding access, tracked by who owns it and its age.
    bit            m_valid = 1'b0;
    bit            m_busy;
    bit            m_who_dm;
    bit            m_last_dm;
    int            m_age;
    logic          m_mem_req;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_we;
    logic          m_if_ack, m_dm_ack;
    logic [DW-1:0] m_if_rdata, m_dm_rdata;
    logic          m_err;
    bit            e_if, e_dm, pick_dm, done;
    logic [DW-1:0] resp;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1; m_busy = 1'b0; m_who_dm = 1'b0; m_last_dm = 1'b1; m_age = 0;
            m_mem_req = 1'b0; m_addr = '0; m_wdata = '0; m_we = 1'b0;
            m_if_ack = 1'b0; m_dm_ack = 1'b0; m_if_rdata = '0; m_dm_rdata = '0; m_err = 1'b0;
        end else if (m_valid) begin
            e_if = if_req && !m_if_ack;
            e_dm = dm_req && !m_dm_ack;
            m_if_ack = 1'b0;
            m_dm_ack = 1'b0;
            if (!m_busy) begin
                if (e_if || e_dm) begin
                    pick_dm   = e_dm && (!e_if || !m_last_dm);
                    m_busy    = 1'b1;
                    m_who_dm  = pick_dm;
                    m_last_dm = pick_dm;
                    m_age     = 0;
                    m_mem_req = 1'b1;
                    m_addr    = pick_dm ? dm_addr : if_addr;
                    m_wdata   = pick_dm ? dm_wdata : '0;
                    m_we      = pick_dm ? dm_we : 1'b0;
                end
            end else begin
                done = 1'b0;
                resp = 32'hDEADBEEF;
                if (mem_ack_drv) begin
                    resp = mem_rdata_drv;
                    done = 1'b1;
                end else begin
                    m_age = m_age + 1;
                    if (m_age >= TO) begin
                        m_err = 1'b1;
                        done  = 1'b1;
                    end
                end
                if (done) begin
                    m_busy    = 1'b0;
                    m_mem_req = 1'b0;
                    if (m_who_dm) begin
                        m_dm_ack = 1'b1; m_dm_rdata = resp;
                    end else begin
                        m_if_ack = 1'b1; m_if_rdata = resp;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the reference, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("mem_req", 64'(mem_req), 64'(m_mem_req));
            check("owner", 64'(owner), m_busy ? (m_who_dm ? 64'd2 : 64'd1) : 64'd0);
            check("if_ack", 64'(if_ack), 64'(m_if_ack));
            check("dm_ack", 64'(dm_ack), 64'(m_dm_ack));
            check("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
            check("dm_rdata", 64'(dm_rdata), 64'(m_dm_rdata));
            check("timeout_err", 64'(timeout_err), 64'(m_err));
            if (m_mem_req) begin
                check("mem_addr", 64'(mem_addr), 64'(m_addr));
                check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
                check("mem_we", 64'(mem_we), 64'(m_we));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack_drv = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    int ng;
    int order[4];
    int rise_at[4];
    int cnt;
    logic prev_req;

    initial begin
        // Reset values
        do_reset();
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_acks", 64'({if_ack, dm_ack}), 64'd0);
        check("rst_rdata", 64'(if_rdata | dm_rdata), 64'd0);
        check("rst_err", 64'(timeout_err), 64'd0);

        // Single fetch, ack after three busy cycles
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        check("if_grant_req", 64'(mem_req), 64'd1);
        check("if_grant_addr", 64'(mem_addr), 64'h100);
        check("if_grant_we", 64'(mem_we), 64'd0);
        check("if_grant_owner", 64'(owner), 64'd1);
        tick();
        tick();
        mem_ack_drv = 1'b1; mem_rdata_drv = 32'h12345678;
        tick();
        check("if_done_ack", 64'(if_ack), 64'd1);
        check("if_done_rdata", 64'(if_rdata), 64'h12345678);
        check("if_done_dm_ack", 64'(dm_ack), 64'd0);
        check("if_done_mem_req", 64'(mem_req), 64'd0);
        check("model_if_rdata", 64'(m_if_rdata), 64'h12345678);
        if_req = 1'b0; mem_ack_drv = 1'b0; mem_rdata_drv = 32'h0;
        tick();
        check("if_ack_pulse", 64'(if_ack), 64'd0);
        check("if_rdata_hold", 64'(if_rdata), 64'h12345678);

        // Continuous tie: alternating grants, one idle cycle apart
        do_reset();
        if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h10; dm_addr = 32'h20;
        ng = 0; prev_req = 1'b0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            tick();
            if (mem_req && !prev_req) begin
                order[ng] = int'(owner);
                rise_at[ng] = c;
                ng++;
            end
            prev_req = mem_req;
            mem_ack_drv = mem_req;
        end
        check("tie_grants", 64'(ng), 64'd4);
        check("tie_order0", 64'(order[0]), 64'd1);
        check("tie_order1", 64'(order[1]), 64'd2);
        check("tie_order2", 64'(order[2]), 64'd1);
        check("tie_order3", 64'(order[3]), 64'd2);
        for (int k = 1; k < 4; k++) check("tie_spacing", 64'(rise_at[k] - rise_at[k-1]), 64'd2);

        // Data write: captured fields hold while busy, requester drops req mid-flight
        do_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hCAFEF00D;
        tick();
        dm_addr = 32'h300; dm_wdata = 32'h0; dm_we = 1'b0; dm_req = 1'b0;
        tick();
        check("dm_hold_addr", 64'(mem_addr), 64'h200);
        check("dm_hold_we", 64'(mem_we), 64'd1);
        check("dm_hold_wdata", 64'(mem_wdata), 64'hCAFEF00D);
        check("dm_hold_req", 64'(mem_req), 64'd1);
        mem_ack_drv = 1'b1; mem_rdata_drv = 32'h55AA;
        tick();
        check("dm_done_ack", 64'(dm_ack), 64'd1);
        check("dm_done_rdata", 64'(dm_rdata), 64'h55AA);
        check("dm_done_if_ack", 64'(if_ack), 64'd0);
        mem_ack_drv = 1'b0;
        tick();
        check("dm_ack_pulse", 64'(dm_ack), 64'd0);

        // Timeout abort after TO busy cycles; error is sticky
        do_reset();
        dm_req = 1'b1; dm_addr = 32'h40;
        tick();
        cnt = 0;
        while (mem_req && cnt < 20) begin
            cnt++;
            tick();
        end
        check("to_busy_cycles", 64'(cnt), 64'd4);
        check("to_dm_ack", 64'(dm_ack), 64'd1);
        check("to_dm_rdata", 64'(dm_rdata), 64'hDEADBEEF);
        check("to_err", 64'(timeout_err), 64'd1);
        check("model_err", 64'(m_err), 64'd1);
        dm_req = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h8;
        tick();
        if_req = 1'b0; mem_ack_drv = 1'b1; mem_rdata_drv = 32'h1;
        tick();
        check("to_next_if_ack", 64'(if_ack), 64'd1);
        check("to_err_sticky", 64'(timeout_err), 64'd1);
        mem_ack_drv = 1'b0;
        do_reset();
        check("to_err_cleared", 64'(timeout_err), 64'd0);

        // Ack on the expiry cycle wins
        if_req = 1'b1; if_addr = 32'h80;
        tick();
        tick(); tick(); tick();
        mem_ack_drv = 1'b1; mem_rdata_drv = 32'h0BADF00D;
        tick();
        check("edge_if_ack", 64'(if_ack), 64'd1);
        check("edge_if_rdata", 64'(if_rdata), 64'h0BADF00D);
        check("edge_err", 64'(timeout_err), 64'd0);
        if_req = 1'b0; mem_ack_drv = 1'b0;
        tick();

        // Reset mid-transaction: no ack, late mem_ack ignored, tie favours IF afterwards
        do_reset();
        dm_req = 1'b1; dm_addr = 32'h4;
        tick();
        dm_req = 1'b0; mem_ack_drv = 1'b1; mem_rdata_drv = 32'hABCD;
        tick();
        mem_ack_drv = 1'b0; if_req = 1'b1; if_addr = 32'hC;
        tick();
        check("rb_if_busy", 64'(owner), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        check("rb_mem_req", 64'(mem_req), 64'd0);
        check("rb_owner", 64'(owner), 64'd0);
        check("rb_dm_rdata", 64'(dm_rdata), 64'd0);
        rst = 1'b0; if_req = 1'b0; mem_ack_drv = 1'b1; mem_rdata_drv = 32'h777;
        tick();
        check("rb_no_if_ack", 64'(if_ack), 64'd0);
        check("rb_idle_req", 64'(mem_req), 64'd0);
        mem_ack_drv = 1'b0; if_req = 1'b1; dm_req = 1'b1;
        tick();
        check("rb_tie_if", 64'(owner), 64'd1);

        // Random traffic against the reference
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (if_req) begin
                if (if_ack) if_req = 1'($urandom_range(0, 1));
                else if ($urandom_range(0, 19) == 0) if_req = 1'b0;
                if ($urandom_range(0, 7) == 0) if_addr = $urandom;
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (dm_req) begin
                if (dm_ack) dm_req = 1'($urandom_range(0, 1));
                else if ($urandom_range(0, 19) == 0) dm_req = 1'b0;
                if ($urandom_range(0, 7) == 0) begin
                    dm_addr = $urandom; dm_wdata = $urandom; dm_we = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 2) == 0) begin
                dm_req = 1'b1; dm_addr = $urandom; dm_wdata = $urandom; dm_we = 1'($urandom_range(0, 1));
            end
            mem_ack_drv   = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            mem_rdata_drv = $urandom;
            tick();
        end
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; mem_ack_drv = 1'b0;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
